// File: rtl/snake_move_ctrl.sv
// snake_move_ctrl
//   Front end of the snake game logic. Takes decoded NEC remote key codes,
//   queues direction keys, rejects reversals and unknown codes, handles the
//   pause toggle and predicts the next head position so that a move into a
//   wall or into the body is never presented to the game logic.
//
// Ports
//   game_clk     game tick clock, one snake move per rising edge
//   reset_n      asynchronous active-low reset
//   i_ir_code    decoded remote code, qualified by i_ir_valid
//   i_ir_valid   one-cycle key strobe
//   i_positions  snake cells, [0] = head, cell = row*16 + col
//   i_length     current snake length (1..255)
//   o_direction  key code driven to the game logic, 32'h0 = no move
//   o_game_over  latched collision flag
//   o_paused     high while paused
//   o_state      0=IDLE 1=RUN 2=PAUSED 3=OVER
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for the first direction key
// RUN    | moving in r_cur_dir, one key popped per tick
// PAUSED | frozen, queue flushed, only PAUSE is recognised
// OVER   | collision predicted, terminal until reset_n

module snake_move_ctrl #(
    parameter logic [31:0] UP         = 32'h20DF6A95,
    parameter logic [31:0] DOWN       = 32'h20DFEA15,
    parameter logic [31:0] LEFT       = 32'h20DF1AE5,
    parameter logic [31:0] RIGHT      = 32'h20DF9A65,
    parameter logic [31:0] PAUSE      = 32'h20DF22DD,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic              game_clk,
    input  logic              reset_n,
    input  logic [31:0]       i_ir_code,
    input  logic              i_ir_valid,
    input  logic [255:0][7:0] i_positions,
    input  logic [7:0]        i_length,
    output logic [31:0]       o_direction,
    output logic              o_game_over,
    output logic              o_paused,
    output logic [1:0]        o_state
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_OVER   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_cur_dir;
    logic [31:0]        r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_game_over;
    logic               r_paused;

    logic               w_key_dir;
    logic               w_key_pause;
    logic               w_empty;
    logic               w_full;
    logic [31:0]        w_fifo_head;
    logic               w_push;
    logic               w_push_ok;
    logic               w_pop;
    logic               w_load;
    logic               w_flush;
    logic               w_reversal;
    logic [7:0]         w_head;
    logic [7:0]         w_next_head;
    logic               w_wall;
    logic               w_self;
    logic               w_hit;

    function automatic logic [31:0] f_opposite(input logic [31:0] code);
        logic [31:0] opp;
        opp = '0;
        if (code == UP)    opp = DOWN;
        if (code == DOWN)  opp = UP;
        if (code == LEFT)  opp = RIGHT;
        if (code == RIGHT) opp = LEFT;
        return opp;
    endfunction

    assign w_key_dir   = i_ir_valid && ((i_ir_code == UP) || (i_ir_code == DOWN) ||
                                        (i_ir_code == LEFT) || (i_ir_code == RIGHT));
    assign w_key_pause = i_ir_valid && (i_ir_code == PAUSE);
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_fifo_head = r_fifo[r_rd_ptr];
    assign w_reversal  = (w_fifo_head == f_opposite(r_cur_dir)) && (i_length >= 8'd2);

    // Walls are tested before the next head is used, so the 8-bit wrap of
    // w_next_head at the board edge never matters.
    always_comb begin
        w_head      = i_positions[0];
        w_next_head = w_head;
        w_wall      = 1'b0;
        if (r_cur_dir == UP) begin
            w_wall      = (w_head < 8'd16);
            w_next_head = w_head - 8'd16;
        end else if (r_cur_dir == DOWN) begin
            w_wall      = (w_head >= 8'd240);
            w_next_head = w_head + 8'd16;
        end else if (r_cur_dir == LEFT) begin
            w_wall      = (w_head[3:0] == 4'd0);
            w_next_head = w_head - 8'd1;
        end else if (r_cur_dir == RIGHT) begin
            w_wall      = (w_head[3:0] == 4'd15);
            w_next_head = w_head + 8'd1;
        end

        // The tail cell (length-1) vacates on this move, so only 1..length-2
        // can be hit; for length < 3 the range is empty.
        w_self = 1'b0;
        for (int i = 1; i < 256; i++) begin
            if (((i + 2) <= int'(i_length)) && (i_positions[i[7:0]] == w_next_head))
                w_self = 1'b1;
        end

        w_hit = (r_state == S_RUN) && (w_wall || w_self);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_push = w_key_dir;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_hit) begin
                    // collision wins over both the pending pop and PAUSE
                    w_state_nxt = S_OVER;
                    w_flush     = 1'b1;
                end else begin
                    w_pop  = !w_empty;
                    w_load = !w_empty && !w_reversal;
                    if (w_key_pause) begin
                        w_state_nxt = S_PAUSED;
                        w_flush     = 1'b1;
                    end else begin
                        w_push = w_key_dir;
                    end
                end
            end
            S_PAUSED: begin
                if (w_key_pause)
                    w_state_nxt = S_RUN;
            end
            S_OVER: begin
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Fullness is judged on the pre-edge count, so a push onto a full queue
    // is dropped even when a pop happens on the same edge.
    assign w_push_ok = w_push && !w_full && !w_flush;

    always_ff @(posedge game_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_game_over <= 1'b0;
            r_paused    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_game_over <= (w_state_nxt == S_OVER);
            r_paused    <= (w_state_nxt == S_PAUSED);
        end
    end

    always_ff @(posedge game_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur_dir <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_load)
                r_cur_dir <= w_fifo_head;
            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push_ok)
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
            end
        end
    end

    // Queue storage needs no reset: an entry is only read after it is written.
    always_ff @(posedge game_clk) begin
        if (w_push_ok)
            r_fifo[r_wr_ptr] <= i_ir_code;
    end

    assign o_direction = ((r_state == S_RUN) && !w_hit) ? r_cur_dir : 32'h0;
    assign o_game_over = r_game_over;
    assign o_paused    = r_paused;
    assign o_state     = r_state;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Testbench for snake_move_ctrl. A small snake model plays the part of the
// game logic (it moves on whatever direction the DUT presents), and a
// reference model of the key queue / game state predicts every output.

module tb_snake_move_ctrl;

    localparam logic [31:0] K_UP    = 32'h20DF6A95;
    localparam logic [31:0] K_DOWN  = 32'h20DFEA15;
    localparam logic [31:0] K_LEFT  = 32'h20DF1AE5;
    localparam logic [31:0] K_RIGHT = 32'h20DF9A65;
    localparam logic [31:0] K_PAUSE = 32'h20DF22DD;
    localparam int          DEPTH   = 2;

    logic              game_clk = 1'b0;
    logic              reset_n  = 1'b0;
    logic [31:0]       ir_code  = 32'h0;
    logic              ir_valid = 1'b0;
    logic [255:0][7:0] positions = '0;
    logic [7:0]        length    = 8'd1;
    logic [31:0]       o_direction;
    logic              o_game_over;
    logic              o_paused;
    logic [1:0]        o_state;

    snake_move_ctrl dut (
        .game_clk    (game_clk),
        .reset_n     (reset_n),
        .i_ir_code   (ir_code),
        .i_ir_valid  (ir_valid),
        .i_positions (positions),
        .i_length    (length),
        .o_direction (o_direction),
        .o_game_over (o_game_over),
        .o_paused    (o_paused),
        .o_state     (o_state)
    );

    always #5 game_clk = ~game_clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          body[$];
    int          m_state;          // 0 idle, 1 run, 2 paused, 3 over
    logic [31:0] m_cur;
    logic [31:0] m_q[$];
    logic [31:0] dut_dir_pre;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int delta(input logic [31:0] c);
        if (c == K_UP)    return -16;
        if (c == K_DOWN)  return 16;
        if (c == K_LEFT)  return -1;
        if (c == K_RIGHT) return 1;
        return 0;
    endfunction

    function automatic bit is_dir(input logic [31:0] c);
        return delta(c) != 0;
    endfunction

    // Board geometry in row/col terms rather than cell arithmetic.
    function automatic bit m_collide();
        int r, c, nr, nc, nh, d;
        if (m_state != 1) return 1'b0;
        r  = body[0] / 16;
        c  = body[0] % 16;
        d  = delta(m_cur);
        nr = r + ((d == 16) ? 1 : (d == -16) ? -1 : 0);
        nc = c + ((d == 1) ? 1 : (d == -1) ? -1 : 0);
        if (nr < 0 || nr > 15 || nc < 0 || nc > 15) return 1'b1;
        nh = nr * 16 + nc;
        for (int i = 1; i <= body.size() - 2; i++)
            if (body[i] == nh) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_dir();
        return (m_state == 1 && !m_collide()) ? m_cur : 32'h0;
    endfunction

    task automatic model_step(input logic v, input logic [31:0] code);
        bit          hit;
        int          pre;
        logic [31:0] k;
        hit = m_collide();
        pre = m_q.size();
        case (m_state)
            0: begin
                if (pre > 0) begin
                    m_cur   = m_q.pop_front();
                    m_state = 1;
                end
                if (v && is_dir(code) && pre < DEPTH) m_q.push_back(code);
            end
            1: begin
                if (hit) begin
                    m_state = 3;
                    m_q.delete();
                end else begin
                    if (pre > 0) begin
                        k = m_q.pop_front();
                        if (!((delta(k) + delta(m_cur) == 0) && body.size() >= 2))
                            m_cur = k;
                    end
                    if (v && code == K_PAUSE) begin
                        m_state = 2;
                        m_q.delete();
                    end else if (v && is_dir(code) && pre < DEPTH) begin
                        m_q.push_back(code);
                    end
                end
            end
            2: if (v && code == K_PAUSE) m_state = 1;
            default: ;
        endcase
    endtask

    task automatic drive_pos();
        for (int i = 0; i < 256; i++)
            positions[i] = (i < body.size()) ? 8'(body[i]) : 8'($urandom);
        length = 8'(body.size());
    endtask

    task automatic step(input logic v, input logic [31:0] code);
        int nh;
        @(negedge game_clk);
        ir_valid = v;
        ir_code  = code;
        drive_pos();
        #1;
        chk("direction", o_direction, m_dir());
        chk("state", 32'(o_state), 32'(m_state));
        chk("paused", 32'(o_paused), 32'(m_state == 2));
        chk("game_over", 32'(o_game_over), 32'(m_state == 3));
        dut_dir_pre = o_direction;
        @(posedge game_clk);
        model_step(v, code);
        if (dut_dir_pre != 32'h0) begin
            nh = (body[0] + delta(dut_dir_pre)) & 255;
            body.push_front(nh);
            void'(body.pop_back());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge game_clk);
        #2;
        reset_n  = 1'b0;
        ir_valid = 1'b0;
        #1;
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_game_over", 32'(o_game_over), 32'd0);
        chk("rst_paused", 32'(o_paused), 32'd0);
        chk("rst_direction", o_direction, 32'h0);
        m_state = 0;
        m_cur   = 32'h0;
        m_q.delete();
        @(negedge game_clk);
        reset_n = 1'b1;
    endtask

    task automatic set_line(input int head, input int len);
        body.delete();
        for (int i = 0; i < len; i++) body.push_back(head - i);
    endtask

    function automatic logic [31:0] rand_key();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1:    return K_UP;
            2, 3:    return K_DOWN;
            4, 5:    return K_LEFT;
            6, 9:    return K_RIGHT;
            7:       return K_PAUSE;
            default: return ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [31:0] wall_key [4];
        int          wall_head[4];
        int          wall_step[4];

        m_state = 0;
        m_cur   = 32'h0;
        set_line(58, 3);
        drive_pos();
        #1;
        chk("init_state", 32'(o_state), 32'd0);
        chk("init_direction", o_direction, 32'h0);

        // first key: RUN after edge 2, move at edge 3
        do_reset();
        step(1'b1, K_RIGHT);
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        chk("first_move_head", 32'(body[0]), 32'd59);
        idle(2);

        // reversal rejected at length 4
        set_line(70, 4);
        do_reset();
        step(1'b1, K_RIGHT);
        idle(2);
        step(1'b1, K_LEFT);
        idle(3);
        chk("reversal_head", 32'(body[0]), 32'd75);

        // UP then DOWN back to back: DOWN is a reversal of the new UP
        set_line(100, 3);
        do_reset();
        step(1'b1, K_RIGHT);
        idle(2);
        step(1'b1, K_UP);
        step(1'b1, K_DOWN);
        idle(3);

        // burst of three keys
        set_line(136, 3);
        do_reset();
        step(1'b1, K_RIGHT);
        step(1'b1, K_UP);
        step(1'b1, K_LEFT);
        idle(3);

        // each wall
        wall_key[0] = K_RIGHT; wall_head[0] = 15;  wall_step[0] = -1;
        wall_key[1] = K_DOWN;  wall_head[1] = 240; wall_step[1] = -16;
        wall_key[2] = K_LEFT;  wall_head[2] = 0;   wall_step[2] = 1;
        wall_key[3] = K_UP;    wall_head[3] = 5;   wall_step[3] = 16;
        for (int w = 0; w < 4; w++) begin
            body.delete();
            for (int i = 0; i < 3; i++) body.push_back(wall_head[w] + i * wall_step[w]);
            do_reset();
            step(1'b1, wall_key[w]);
            step(1'b1, K_PAUSE);
            idle(2);
            #1;
            chk("wall_over_state", 32'(o_state), 32'd3);
            chk("wall_head_kept", 32'(body[0]), 32'(wall_head[w]));
        end

        // self collision, then same shape too short to bite itself
        body = '{37, 21, 22, 38, 39};
        do_reset();
        step(1'b1, K_UP);
        idle(3);
        #1;
        chk("self_over_state", 32'(o_state), 32'd3);
        body = '{37, 21};
        do_reset();
        step(1'b1, K_UP);
        idle(2);
        #1;
        chk("short_no_hit_state", 32'(o_state), 32'd1);

        // pause / resume, then reset out of OVER
        set_line(120, 3);
        do_reset();
        step(1'b1, K_RIGHT);
        idle(2);
        step(1'b1, K_DOWN);
        step(1'b1, K_PAUSE);
        step(1'b1, K_LEFT);
        idle(2);
        step(1'b1, K_PAUSE);
        idle(3);
        set_line(14, 2);
        do_reset();
        step(1'b1, K_RIGHT);
        idle(3);
        do_reset();

        // random games
        for (int g = 0; g < 30; g++) begin
            set_line($urandom_range(3, 12) * 16 + $urandom_range(5, 11), $urandom_range(1, 5));
            do_reset();
            for (int s = 0; s < 60; s++) begin
                if ($urandom_range(0, 99) < 35) step(1'b1, rand_key());
                else                           step(1'b0, 32'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
